prog_load_ctrl: RTL and testbench

Program-load sequencer for the 8-bit CPU's 32-entry instruction memory. Accepts a framed byte stream (length, payload, XOR checksum) over a valid/ready byte interface and clears the instruction memory's write pointer. It then writes the payload into memory in order and holds the CPU in halt until the image is verified. On success it releases the CPU to run from PC 0; on failure it latches an error code and keeps the CPU halted.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/rx_timeout.sv | 29 ++
 rtl/prog_load_ctrl.sv | 157 +++++++++++++++
 tb/tb_prog_load_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU program loader
package cpu_pkg;

  localparam int PROG_DEPTH = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } load_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rx_timeout.sv
// rtl/rx_timeout.sv - saturating idle counter between accepted bytes
module rx_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic CPU_Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // count idle cycles while enabled, hold at TIMEOUT, restart on clr
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/prog_load_ctrl.sv
// rtl/prog_load_ctrl.sv - framed program-load sequencer for the instruction memory
module prog_load_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH   = PROG_DEPTH,
  parameter int TIMEOUT = 1023
) (
  input  logic       CPU_Clk,
  input  logic       Reset,
  input  logic       load_req,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_clr,
  output logic       mem_wr,
  output logic [7:0] mem_data,
  input  logic       mem_full,
  output logic       cpu_hold,
  output logic       cpu_run,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic [5:0] byte_cnt
);

  localparam logic [7:0] MAX_LEN = 8'(DEPTH - 1);

  load_state_t state, state_nxt;
  logic [5:0]  len_q;
  logic [7:0]  csum_q;
  logic        accept;
  logic        in_load;
  logic        to_clr;
  logic        to_expire;
  logic        set_err;
  logic [1:0]  err_nxt;

  // byte acceptance is decided by state (and memory full in DATA), never by rx_valid
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_LEN, S_CSUM: rx_ready = 1'b1;
      S_DATA:        rx_ready = !mem_full;
      default:       rx_ready = 1'b0;
    endcase
  end

  assign accept   = rx_valid && rx_ready;
  assign mem_clr  = (state == S_CLEAR);
  assign cpu_run  = (state == S_RUN);
  assign cpu_hold = !cpu_run;
  assign err      = (state == S_ERR);
  assign in_load  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy     = in_load || (state == S_CLEAR);
  assign to_clr   = mem_clr || accept;

  rx_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .CPU_Clk(CPU_Clk),
    .Reset  (Reset),
    .clr    (to_clr),
    .en     (in_load),
    .expire (to_expire)
  );

  // next-state decode; set_err/err_nxt carry the code latched on entry to ERR
  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    err_nxt   = ERR_NONE;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req) state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_LEN;
      S_LEN: begin
        if (accept) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN)) begin
            state_nxt = S_ERR;
            set_err   = 1'b1;
            err_nxt   = ERR_LEN;
          end else begin
            state_nxt = S_DATA;
          end
        end else if (to_expire) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (accept) begin
          if ((byte_cnt + 6'd1) == len_q) state_nxt = S_CSUM;
        end else if (mem_full) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
          err_nxt   = ERR_LEN;
        end else if (to_expire) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_ERR;
            set_err   = 1'b1;
            err_nxt   = ERR_CSUM;
          end
        end else if (to_expire) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // load datapath: length, checksum, count, error code and the registered write port
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      len_q    <= '0;
      csum_q   <= '0;
      byte_cnt <= '0;
      err_code <= ERR_NONE;
      mem_wr   <= 1'b0;
      mem_data <= '0;
    end else begin
      mem_wr <= (state == S_DATA) && accept;
      if ((state == S_DATA) && accept) begin
        mem_data <= rx_data;
        csum_q   <= csum_q ^ rx_data;
        byte_cnt <= byte_cnt + 6'd1;
      end
      if ((state == S_LEN) && accept) len_q <= rx_data[5:0];
      if (mem_clr) begin
        csum_q   <= '0;
        byte_cnt <= '0;
        err_code <= ERR_NONE;
      end else if (set_err) begin
        err_code <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb/tb_prog_load_ctrl.sv - scoreboard bench for prog_load_ctrl
module tb_prog_load_ctrl;
  import cpu_pkg::*;

  logic       CPU_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, mem_clr, mem_wr, mem_full;
  logic [7:0] mem_data;
  logic       cpu_hold, cpu_run, busy, err;
  logic [1:0] err_code;
  logic [5:0] byte_cnt;

  prog_load_ctrl dut (
    .CPU_Clk (CPU_Clk),
    .Reset   (Reset),
    .load_req(load_req),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_clr (mem_clr),
    .mem_wr  (mem_wr),
    .mem_data(mem_data),
    .mem_full(mem_full),
    .cpu_hold(cpu_hold),
    .cpu_run (cpu_run),
    .busy    (busy),
    .err     (err),
    .err_code(err_code),
    .byte_cnt(byte_cnt)
  );

  always #5 CPU_Clk = ~CPU_Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // instruction memory occupancy: full after DEPTH-1 writes, or forced
  int wcount;
  bit force_full = 1'b0;
  always @(posedge CPU_Clk or posedge Reset) begin
    if (Reset)        wcount <= 0;
    else if (mem_clr) wcount <= 0;
    else if (mem_wr)  wcount <= wcount + 1;
  end
  assign mem_full = force_full || (wcount >= PROG_DEPTH - 1);

  typedef struct {
    bit run;
    int code;
    int cnt;
  } outc_t;

  logic [7:0] wq[$];
  outc_t      oq[$];
  bit         sb_en = 1'b1;
  int         clr_cnt = 0;
  bit         prev_busy = 1'b0;

  // monitor: compares every write and every load outcome against the queues
  initial begin
    logic [7:0] ew;
    outc_t      o;
    forever begin
      @(negedge CPU_Clk);
      if (sb_en && !Reset) begin
        if (mem_clr) clr_cnt++;
        if (mem_wr) begin
          if (clr_cnt == 0) fail("write_before_clr");
          if (wq.size() == 0) fail("unexpected_write");
          else begin
            ew = wq.pop_front();
            chk("mem_data", int'(mem_data), int'(ew));
          end
        end
        if (prev_busy && !busy) begin
          if (oq.size() == 0) fail("unexpected_end");
          else begin
            o = oq.pop_front();
            chk("cpu_run", int'(cpu_run), int'(o.run));
            chk("cpu_hold", int'(cpu_hold), int'(!o.run));
            chk("err", int'(err), int'(!o.run));
            chk("err_code", int'(err_code), o.code);
            chk("byte_cnt", int'(byte_cnt), o.cnt);
            chk("rx_ready_after", int'(rx_ready), 0);
            chk("clr_pulses", clr_cnt, 1);
            chk("writes_left", wq.size(), 0);
            clr_cnt = 0;
          end
        end
      end
      prev_busy = busy;
    end
  end

  // reference model: frame rules computed directly from the bytes offered
  task automatic expect_frame(input logic [7:0] q[$], input int n_send, input int fault);
    int len, p;
    logic [7:0] x;
    outc_t o;
    len = int'(q[0]);
    if (len == 0 || len > PROG_DEPTH - 1) begin
      o.run = 0; o.code = 1; o.cnt = 0;
    end else begin
      p = (n_send - 1 < len) ? n_send - 1 : len;
      for (int i = 1; i <= p; i++) wq.push_back(q[i]);
      if (p < len) begin
        o.run = 0; o.code = (fault == 2) ? 1 : 3; o.cnt = p;
      end else begin
        x = 8'h00;
        for (int i = 1; i <= len; i++) x = x ^ q[i];
        o.cnt = len;
        if (q[len+1] == x) begin o.run = 1; o.code = 0; end
        else begin o.run = 0; o.code = 2; end
      end
    end
    oq.push_back(o);
  endtask

  task automatic start_load();
    @(negedge CPU_Clk);
    load_req = 1'b1;
    @(negedge CPU_Clk);
    load_req = 1'b0;
    chk("start_mem_clr", int'(mem_clr), 1);
    chk("start_cpu_hold", int'(cpu_hold), 1);
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int n_send, input int gap, input int ldreq_at);
    int g, tries;
    for (int i = 0; i < n_send; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        @(negedge CPU_Clk);
        rx_valid = 1'b0;
        load_req = 1'b0;
      end
      tries = 0;
      do begin
        @(negedge CPU_Clk);
        rx_valid = 1'b1;
        rx_data  = q[i];
        load_req = (ldreq_at == i);
        tries++;
      end while (!rx_ready && tries < 2000);
      if (!rx_ready) fail("rx_ready_wait");
    end
    @(negedge CPU_Clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_outcome();
    int tries = 0;
    while (oq.size() != 0 && tries < 3000) begin
      @(negedge CPU_Clk);
      tries++;
    end
    if (oq.size() != 0) begin
      fail("outcome_wait");
      oq.delete();
      wq.delete();
    end
  endtask

  task automatic do_load(input logic [7:0] q[$], input int n_send, input int gap,
                         input int fault, input int ldreq_at);
    expect_frame(q, n_send, fault);
    start_load();
    send_bytes(q, n_send, gap, ldreq_at);
    if (fault == 2) force_full = 1'b1;
    wait_outcome();
    force_full = 1'b0;
  endtask

  function automatic void make_frame(output logic [7:0] q[$], input int len, input bit good);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    q.delete();
    q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      q.push_back(b);
    end
    q.push_back(good ? x : ~x);
  endfunction

  logic [7:0] fr[$];

  initial begin
    repeat (3) @(negedge CPU_Clk);
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_mem_clr", int'(mem_clr), 0);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_cpu_run", int'(cpu_run), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_byte_cnt", int'(byte_cnt), 0);
    Reset = 1'b0;
    repeat (2) @(negedge CPU_Clk);
    chk("idle_busy", int'(busy), 0);

    fr = '{8'd3, 8'h11, 8'h22, 8'h44, 8'h77};
    do_load(fr, 5, 0, 0, -1);
    fr = '{8'd2, 8'hA5, 8'h5A, 8'h00};
    do_load(fr, 4, 0, 0, -1);
    fr = '{8'd0};
    do_load(fr, 1, 0, 0, -1);
    fr = '{8'd32};
    do_load(fr, 1, 0, 0, -1);
    make_frame(fr, 31, 1'b1);
    do_load(fr, 33, 0, 0, -1);
    make_frame(fr, 1, 1'b1);
    do_load(fr, 3, 1, 0, -1);
    make_frame(fr, 6, 1'b1);
    do_load(fr, 8, 0, 0, 3);
    make_frame(fr, 4, 1'b1);
    do_load(fr, 2, 0, 1, -1);
    make_frame(fr, 5, 1'b1);
    do_load(fr, 3, 0, 2, -1);

    for (int k = 0; k < 6; k++) begin
      make_frame(fr, int'($urandom_range(1, 31)), ($urandom_range(0, 2) != 0));
      do_load(fr, fr.size(), -1, 0, -1);
    end

    // asynchronous reset in the middle of DATA
    sb_en = 1'b0;
    make_frame(fr, 8, 1'b1);
    start_load();
    send_bytes(fr, 3, 0, -1);
    @(negedge CPU_Clk);
    rx_valid = 1'b1;
    rx_data  = fr[3];
    #2 Reset = 1'b1;
    #1;
    chk("arst_rx_ready", int'(rx_ready), 0);
    chk("arst_mem_clr", int'(mem_clr), 0);
    chk("arst_mem_wr", int'(mem_wr), 0);
    chk("arst_mem_data", int'(mem_data), 0);
    chk("arst_cpu_hold", int'(cpu_hold), 1);
    chk("arst_cpu_run", int'(cpu_run), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_err_code", int'(err_code), 0);
    chk("arst_byte_cnt", int'(byte_cnt), 0);
    rx_valid = 1'b0;
    @(negedge CPU_Clk);
    Reset = 1'b0;
    repeat (4) begin
      @(negedge CPU_Clk);
      chk("post_rst_mem_wr", int'(mem_wr), 0);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_hold", int'(cpu_hold), 1);
    end
    wq.delete();
    oq.delete();
    clr_cnt = 0;
    sb_en = 1'b1;

    make_frame(fr, 5, 1'b1);
    do_load(fr, 7, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
